// File: rtl/block_lock_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// block_lock_ctrl_pkg
// Shared 64b/66b definitions for the receive-side block-lock controller:
//   SYNC_DATA / SYNC_CTRL : the two legal sync-header encodings
//   state_t               : block-lock FSM states
//   is_sync_valid()       : 1 when a 2-bit sync header is a legal encoding
// ---------------------------------------------------------------------------
package block_lock_ctrl_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        TEST   = 2'd1,
        SLIP_W = 2'd2
    } state_t;

    function automatic logic is_sync_valid(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/block_lock_ctrl.sv
// ---------------------------------------------------------------------------
// block_lock_ctrl
// 64b/66b receive block-synchronisation controller. Tests the sync header of
// every received block in windows of SH_CNT_MAX headers, commands the rx
// gearbox to slip one bit when alignment is wrong, declares block lock and
// gates the descrambler valid strobe.
//
// Ports:
//   clk           in   clock
//   nreset        in   asynchronous active-low reset
//   signal_ok_i   in   PMA signal detect; low forces re-initialisation
//   hdr_v_i       in   sync header present on hdr_i this cycle
//   hdr_i         in   2-bit sync header
//   slip_o        out  one-cycle pulse: gearbox shifts alignment by one bit
//   block_lock_o  out  block lock achieved (registered)
//   valid_o       out  combinational valid for the rx descrambler
//   slip_cnt_o    out  saturating count of slips issued
// ---------------------------------------------------------------------------
module block_lock_ctrl
    import block_lock_ctrl_pkg::*;
#(
    parameter int SH_CNT_MAX = 64,
    parameter int SH_INV_MAX = 16,
    parameter int SLIP_WAIT  = 4,
    parameter int SLIP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  signal_ok_i,
    input  logic                  hdr_v_i,
    input  logic [1:0]            hdr_i,
    output logic                  slip_o,
    output logic                  block_lock_o,
    output logic                  valid_o,
    output logic [SLIP_CNT_W-1:0] slip_cnt_o
);

    localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
    localparam int INV_W  = $clog2(SH_INV_MAX + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SH_CNT_MAX);
    localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INV_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

    state_t                  state_q;
    logic [CNT_W-1:0]        sh_cnt_q;
    logic [INV_W-1:0]        inv_cnt_q;
    logic [WAIT_W-1:0]       wait_cnt_q;
    logic                    slip_q;
    logic                    block_lock_q;
    logic [SLIP_CNT_W-1:0]   slip_cnt_q;

    // Candidate counter values if the current header is accepted into the window.
    logic                    hdr_bad;
    logic [CNT_W-1:0]        sh_cnt_d;
    logic [INV_W-1:0]        inv_cnt_d;

    assign hdr_bad   = !is_sync_valid(hdr_i);
    assign sh_cnt_d  = sh_cnt_q + CNT_W'(1);
    assign inv_cnt_d = inv_cnt_q + INV_W'(hdr_bad);

    // NOTE: every register here is assigned with <= so all of them update
    // from the same pre-edge values, whatever order the statements appear in.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= INIT;
            sh_cnt_q     <= '0;
            inv_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            slip_q       <= 1'b0;
            block_lock_q <= 1'b0;
            slip_cnt_q   <= '0;
        end else begin
            // slip_o is a pulse: low unless this edge issues a slip.
            slip_q <= 1'b0;
            if (!signal_ok_i) begin
                // Loss of signal restarts acquisition; the slip count survives.
                state_q      <= INIT;
                sh_cnt_q     <= '0;
                inv_cnt_q    <= '0;
                wait_cnt_q   <= '0;
                block_lock_q <= 1'b0;
            end else begin
                case (state_q)
                    INIT: begin
                        state_q      <= TEST;
                        sh_cnt_q     <= '0;
                        inv_cnt_q    <= '0;
                        wait_cnt_q   <= '0;
                        block_lock_q <= 1'b0;
                    end
                    TEST: begin
                        if (hdr_v_i) begin
                            if (hdr_bad && (!block_lock_q || inv_cnt_d == INV_LAST)) begin
                                state_q      <= SLIP_W;
                                block_lock_q <= 1'b0;
                                slip_q       <= 1'b1;
                                sh_cnt_q     <= '0;
                                inv_cnt_q    <= '0;
                                wait_cnt_q   <= '0;
                                if (slip_cnt_q != '1) begin
                                    slip_cnt_q <= slip_cnt_q + SLIP_CNT_W'(1);
                                end
                            end else if (sh_cnt_d == CNT_LAST) begin
                                // Window complete: only a fully clean window grants lock.
                                if (inv_cnt_d == '0) begin
                                    block_lock_q <= 1'b1;
                                end
                                sh_cnt_q  <= '0;
                                inv_cnt_q <= '0;
                            end else begin
                                sh_cnt_q  <= sh_cnt_d;
                                inv_cnt_q <= inv_cnt_d;
                            end
                        end
                    end
                    SLIP_W: begin
                        // Gearbox is realigning; headers seen now are meaningless.
                        if (wait_cnt_q == WAIT_LAST) begin
                            state_q    <= TEST;
                            wait_cnt_q <= '0;
                            sh_cnt_q   <= '0;
                            inv_cnt_q  <= '0;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= INIT;
                    end
                endcase
            end
        end
    end

    assign slip_o       = slip_q;
    assign block_lock_o = block_lock_q;
    assign slip_cnt_o   = slip_cnt_q;
    assign valid_o      = block_lock_q & hdr_v_i & (state_q == TEST);

endmodule

// File: tb/tb_block_lock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_block_lock_ctrl
// Self-checking bench for block_lock_ctrl. A behavioural model tracks the
// current header window as a queue of pass/fail bits, a blind-cycle count
// after each slip and an init flag; every cycle the DUT outputs are compared
// against it, plus directed checks at the interesting boundaries.
// ---------------------------------------------------------------------------
module tb_block_lock_ctrl;
    import block_lock_ctrl_pkg::*;

    localparam int WIN       = 64;
    localparam int INV_LIMIT = 16;
    localparam int BLIND     = 4;
    localparam int CNT_SAT   = 255;

    logic       clk = 1'b0;
    logic       nreset;
    logic       signal_ok_i;
    logic       hdr_v_i;
    logic [1:0] hdr_i;
    logic       slip_o;
    logic       block_lock_o;
    logic       valid_o;
    logic [7:0] slip_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit m_init;
    int m_blind;
    bit m_lock;
    bit m_slip;
    int m_slip_cnt;
    bit m_win[$];

    block_lock_ctrl dut (
        .clk          (clk),
        .nreset       (nreset),
        .signal_ok_i  (signal_ok_i),
        .hdr_v_i      (hdr_v_i),
        .hdr_i        (hdr_i),
        .slip_o       (slip_o),
        .block_lock_o (block_lock_o),
        .valid_o      (valid_o),
        .slip_cnt_o   (slip_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    endfunction

    function automatic logic [1:0] any_hdr();
        return 2'($urandom_range(0, 3));
    endfunction

    task automatic model_reset();
        m_init     = 1'b1;
        m_blind    = 0;
        m_lock     = 1'b0;
        m_slip     = 1'b0;
        m_slip_cnt = 0;
        m_win.delete();
    endtask

    function automatic bit model_valid(input bit hv);
        return m_lock && hv && !m_init && (m_blind == 0);
    endfunction

    // Advance the model across one clock edge with the given inputs.
    task automatic model_edge(input bit sok, input bit hv, input logic [1:0] hdr);
        bit bad;
        int nbad;
        m_slip = 1'b0;
        if (!sok) begin
            m_init  = 1'b1;
            m_lock  = 1'b0;
            m_blind = 0;
            m_win.delete();
        end else if (m_init) begin
            m_init = 1'b0;
        end else if (m_blind > 0) begin
            m_blind--;
        end else if (hv) begin
            bad = (hdr == 2'b00) || (hdr == 2'b11);
            m_win.push_back(bad);
            nbad = 0;
            foreach (m_win[k]) nbad += int'(m_win[k]);
            if (bad && (!m_lock || nbad == INV_LIMIT)) begin
                m_lock  = 1'b0;
                m_slip  = 1'b1;
                m_blind = BLIND;
                if (m_slip_cnt < CNT_SAT) m_slip_cnt++;
                m_win.delete();
            end else if (m_win.size() == WIN) begin
                if (nbad == 0) m_lock = 1'b1;
                m_win.delete();
            end
        end
    endtask

    // One clock cycle: called just after a rising edge, returns just after the next.
    task automatic step(input bit sok, input bit hv, input logic [1:0] hdr);
        signal_ok_i = sok;
        hdr_v_i     = hv;
        hdr_i       = hdr;
        @(negedge clk);
        check("valid_o", 32'(valid_o), 32'(model_valid(hv)));
        model_edge(sok, hv, hdr);
        @(posedge clk);
        #1;
        check("slip_o", 32'(slip_o), 32'(m_slip));
        check("block_lock_o", 32'(block_lock_o), 32'(m_lock));
        check("slip_cnt_o", 32'(slip_cnt_o), 32'(m_slip_cnt));
    endtask

    // One window of WIN header events with n_bad invalid ones at random
    // positions; stops early if the window triggers a slip.
    task automatic run_window(input int n_bad_hdr, input bit gaps);
        bit bad_slot[WIN];
        int j;
        bit t;
        for (int i = 0; i < WIN; i++) bad_slot[i] = (i < n_bad_hdr);
        for (int i = WIN - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = bad_slot[i];
            bad_slot[i] = bad_slot[j];
            bad_slot[j] = t;
        end
        for (int i = 0; i < WIN; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) step(1'b1, 1'b0, any_hdr());
            step(1'b1, 1'b1, bad_slot[i] ? bad_hdr() : good_hdr());
            if (m_slip) break;
        end
    endtask

    initial begin
        nreset      = 1'b0;
        signal_ok_i = 1'b0;
        hdr_v_i     = 1'b0;
        hdr_i       = 2'b00;
        model_reset();

        // Reset state
        #12;
        check("rst_slip", 32'(slip_o), 32'd0);
        check("rst_lock", 32'(block_lock_o), 32'd0);
        check("rst_cnt", 32'(slip_cnt_o), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(INIT));
        nreset = 1'b1;
        @(posedge clk);
        #1;

        // 1: lock from reset after exactly 64 clean headers
        step(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < WIN - 1; i++) step(1'b1, 1'b1, 2'b01);
        check("lock_before_64", 32'(block_lock_o), 32'd0);
        step(1'b1, 1'b1, 2'b01);
        check("lock_after_64", 32'(block_lock_o), 32'd1);
        check("no_slip_cnt", 32'(slip_cnt_o), 32'd0);
        run_window(0, 1'b1);

        // 3: locked error tolerance
        run_window(INV_LIMIT - 1, 1'b0);
        check("lock_held_15", 32'(block_lock_o), 32'd1);
        check("cnt_after_15", 32'(slip_cnt_o), 32'd0);
        run_window(INV_LIMIT, 1'b0);
        check("slip_at_16", 32'(slip_o), 32'd1);
        check("unlock_at_16", 32'(block_lock_o), 32'd0);
        check("cnt_after_16", 32'(slip_cnt_o), 32'd1);
        for (int i = 0; i < BLIND; i++) step(1'b1, 1'b1, any_hdr());

        // 2: unlocked slip on the 10th header
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, good_hdr());
        step(1'b1, 1'b1, 2'b00);
        check("slip_10th", 32'(slip_o), 32'd1);
        check("cnt_10th", 32'(slip_cnt_o), 32'd2);
        step(1'b1, 1'b1, 2'b01);
        check("slip_one_cycle", 32'(slip_o), 32'd0);
        for (int i = 0; i < BLIND - 1; i++) step(1'b1, 1'b1, bad_hdr());
        run_window(0, 1'b0);
        check("relock", 32'(block_lock_o), 32'd1);

        // 4: single error in a locked window
        run_window(1, 1'b1);
        check("lock_one_err", 32'(block_lock_o), 32'd1);
        check("cnt_one_err", 32'(slip_cnt_o), 32'd2);
        check("sh_cnt_restart", 32'(dut.sh_cnt_q), 32'd0);
        run_window(0, 1'b0);
        check("lock_clean_after", 32'(block_lock_o), 32'd1);

        // 5: header gaps and signal loss
        step(1'b0, 1'b1, 2'b01);
        check("sok_unlock", 32'(block_lock_o), 32'd0);
        step(1'b1, 1'b0, 2'b01);
        for (int i = 0; i < 2 * WIN; i++) step(1'b1, (i % 2) == 0, good_hdr());
        check("lock_by_events", 32'(block_lock_o), 32'd1);
        for (int i = 0; i < 29; i++) step(1'b1, 1'b1, good_hdr());
        step(1'b0, 1'b1, good_hdr());
        check("sok_drop_30", 32'(block_lock_o), 32'd0);
        check("sok_cnt_kept", 32'(slip_cnt_o), 32'd2);
        check("sok_init", 32'(dut.state_q), 32'(INIT));
        step(1'b1, 1'b0, 2'b01);
        check("sok_back_test", 32'(dut.state_q), 32'(TEST));

        // 6: slip counter saturation
        for (int i = 0; i < 300 * (BLIND + 1) + 20; i++) step(1'b1, 1'b1, bad_hdr());
        check("cnt_saturated", 32'(slip_cnt_o), 32'd255);
        for (int i = 0; i < 2 * (BLIND + 1) && !m_slip; i++) step(1'b1, 1'b1, bad_hdr());
        check("in_slip_w", 32'(dut.state_q), 32'(SLIP_W));

        // Asynchronous reset in SLIP_W, between clock edges
        hdr_v_i = 1'b1;
        nreset  = 1'b0;
        #1;
        check("arst_slip", 32'(slip_o), 32'd0);
        check("arst_lock", 32'(block_lock_o), 32'd0);
        check("arst_valid", 32'(valid_o), 32'd0);
        check("arst_cnt", 32'(slip_cnt_o), 32'd0);
        check("arst_state", 32'(dut.state_q), 32'(INIT));
        @(posedge clk);
        #1;
        nreset = 1'b1;
        model_reset();

        step(1'b1, 1'b0, 2'b01);
        run_window(0, 1'b1);
        check("final_lock", 32'(block_lock_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/block_lock_ctrl.md
Name: block_lock_ctrl

Overview:
- Receive-side block-synchronisation controller for the 64b/66b path, following the IEEE 802.3 Clause 49 block-lock state machine.
- Inspects the 2-bit sync header of every received block and commands the rx gearbox to slip alignment by one bit until headers are stable.
- Declares block lock and gates the valid strobe into the rx descrambler, so descrambling only runs on aligned data.

Parameters:
- SH_CNT_MAX, 64: headers per test window.
- SH_INV_MAX, 16: invalid headers within one window that force loss of lock while locked.
- SLIP_WAIT, 4: cycles after a slip during which headers are ignored while the gearbox realigns; must be >= 1.
- SLIP_CNT_W, 8: width of the saturating slip counter.

Ports:
- clk  in  1  clock
- nreset  in  1  reset, asynchronous, active-low
- signal_ok_i  in  1  PMA signal detect; low forces re-initialisation
- hdr_v_i  in  1  a sync header is present on hdr_i this cycle
- hdr_i  in  2  sync header bits
- slip_o  out  1  single-cycle pulse: gearbox shifts block alignment by one bit
- block_lock_o  out  1  block lock achieved
- valid_o  out  1  valid for rx descrambler
- slip_cnt_o  out  SLIP_CNT_W  number of slips issued, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset nreset is asynchronous, active-low.
- Reset state: state=INIT; sh_cnt=0, inv_cnt=0, wait_cnt=0; slip_o=0, block_lock_o=0, slip_cnt_o=0.
- Header validity: a header is valid iff hdr_i is 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid.
- Header events: an event is any cycle with hdr_v_i=1 in state TEST. Cycles with hdr_v_i=0 change no counter.
- valid_o: combinational, valid_o = block_lock_o & hdr_v_i & (state==TEST). Zero latency.
- Counter widths:
  - sh_cnt holds 0..SH_CNT_MAX.
  - inv_cnt holds 0..SH_INV_MAX.
  - wait_cnt holds 0..SLIP_WAIT.
  - The next-state values used below are n_cnt = sh_cnt+1 and n_inv = inv_cnt + invalid.
- State INIT: counters cleared, block_lock_o=0. Moves to TEST on the next cycle with signal_ok_i=1.
- State TEST, on an event, priority order:
  1. If the header is invalid and (block_lock_o=0 or n_inv==SH_INV_MAX): block_lock_o<=0, slip_o<=1 for exactly one cycle, slip_cnt_o increments (saturating at all-ones), sh_cnt and inv_cnt cleared, wait_cnt cleared, go to SLIP_W.
  2. Else if n_cnt==SH_CNT_MAX: if n_inv==0 then block_lock_o<=1, otherwise block_lock_o holds its value. Both counters cleared; stay in TEST.
  3. Else: sh_cnt<=n_cnt, inv_cnt<=n_inv.
- State SLIP_W: hdr_v_i ignored; wait_cnt increments each cycle. When wait_cnt==SLIP_WAIT-1, go to TEST with counters at 0.
- Output latency: all outputs except valid_o are registered.
  - slip_o is high in the cycle after the triggering header.
  - block_lock_o rises in the cycle after the SH_CNT_MAX-th clean header, and falls in the same cycle slip_o is high.
- Consecutive slips: slip_o is never high in two consecutive cycles; SLIP_W guarantees at least SLIP_WAIT cycles between pulses.
- signal_ok_i=0 in any state: the next edge enters INIT. block_lock_o<=0, counters cleared, slip_o<=0. slip_cnt_o is retained; only nreset clears it.
- Async reset mid-operation, including SLIP_W: all outputs are 0 immediately, without waiting for a clock edge.
- Lock is never asserted by a window containing any invalid header.
- While locked, fewer than SH_INV_MAX invalid headers in a window keeps lock and restarts the window.

Decomposition:
- Shared 64b66b package:
  - SYNC_DATA=2'b01, SYNC_CTRL=2'b10
  - state enum {INIT, TEST, SLIP_W}
  - helper function is_sync_valid(hdr)
- No sub-module. A single FSM with counters is the natural size. valid_o feeds the valid_i of the existing rx descrambler directly.

Test Plan:
1. Lock from reset: nreset deasserted, signal_ok_i=1, then 64 consecutive headers of 2'b01 -> block_lock_o=1 exactly one cycle after the 64th header; slip_o never asserted; valid_o follows hdr_v_i thereafter.
2. Unlocked slip: the 10th header is 2'b00 -> one-cycle slip_o pulse the next cycle; slip_cnt_o=1; headers during the next 4 cycles are ignored; lock then requires 64 fresh clean headers.
3. Locked error tolerance: while locked, a window with 15 invalid headers (2'b11) -> lock is held. A window reaching 16 invalid headers -> slip_o=1 and block_lock_o=0 in the same cycle, after the 16th.
4. Locked single error: a window with one invalid header, then a clean window -> block_lock_o stays 1 throughout, no slip; sh_cnt restarts at the window boundary.
5. Header gaps and signal loss: hdr_v_i deasserted on alternating cycles -> lock is reached after 64 events, not 64 cycles. signal_ok_i dropped at header 30 -> block_lock_o=0 next cycle, slip_cnt_o unchanged, INIT→TEST once signal_ok_i returns.
6. Saturation and reset: force 300 slips (all headers invalid) -> slip_cnt_o stops at 255. Pulse nreset low during SLIP_W -> all outputs are 0 asynchronously and state is INIT.
